// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: rebuilds VGA pixel coordinates from sync edges, checks timing, counts lit pixels per frame
// Ports: clk, reset (async active-low); hsync/vsync/rgb from the generator; clr_err clears sticky errors;
//   mon_x/mon_y coordinates, mon_valid/mon_rgb visible pixel strobe, frame_start at (0,0);
//   locked, h_err/v_err sticky timing errors, lit_count lit pixels of last frame, frame_cnt frames seen.
module vga_rx_monitor #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_VIS    = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_TOTAL  = 800,
  parameter int   V_VIS    = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  input  logic        clr_err,
  output logic [9:0]  mon_x,
  output logic [9:0]  mon_y,
  output logic        mon_valid,
  output logic [2:0]  mon_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [18:0] lit_count,
  output logic [15:0] frame_cnt
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state, state_nxt;
  logic hs_r, vs_r, hs_p, vs_p;
  logic [2:0] rgb_r;
  logic [DW-1:0] div;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [18:0] lit;
  logic tick, h_lead, h_trail, v_lead, v_trail, h_wrap, h_fail, v_fail, vis, search;
  assign h_lead  = (hs_r == SYNC_POL) && (hs_p != SYNC_POL);
  assign h_trail = (hs_r != SYNC_POL) && (hs_p == SYNC_POL);
  assign v_lead  = (vs_r == SYNC_POL) && (vs_p != SYNC_POL);
  assign v_trail = (vs_r != SYNC_POL) && (vs_p == SYNC_POL);
  // an hsync leading edge always lands on a tick so the pixel phase follows the generator
  assign tick    = h_lead || div == '0;
  assign h_wrap  = tick && !h_lead && h_cnt == 10'(H_TOTAL - 1);
  assign search  = state == SEARCH;
  assign mon_x   = h_cnt;
  assign mon_y   = v_cnt;
  always_comb begin
    h_nxt = h_lead ? 10'(H_VIS + H_FP) : tick ? (h_wrap ? '0 : h_cnt + 10'd1) : h_cnt;
    v_nxt = v_lead ? 10'(V_VIS + V_FP) : h_wrap ? (v_cnt == 10'(V_TOTAL - 1) ? '0 : v_cnt + 10'd1) : v_cnt;
  end
  // trailing edges are judged on the coordinate this tick lands on
  assign h_fail = !search && ((h_lead && h_cnt != 10'(H_VIS + H_FP - 1)) ||
                              (h_trail && h_nxt != 10'(H_VIS + H_FP + H_SYNC)));
  assign v_fail = !search && ((v_lead && v_cnt != 10'(V_VIS + V_FP - 1)) ||
                              (v_trail && v_nxt != 10'(V_VIS + V_FP + V_SYNC)));
  assign vis    = tick && h_nxt < 10'(H_VIS) && v_nxt < 10'(V_VIS);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      hs_r        <= !SYNC_POL;
      vs_r        <= !SYNC_POL;
      hs_p        <= !SYNC_POL;
      vs_p        <= !SYNC_POL;
      rgb_r       <= '0;
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      mon_valid   <= 1'b0;
      mon_rgb     <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      lit         <= '0;
      lit_count   <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      hs_r        <= hsync;
      vs_r        <= vsync;
      hs_p        <= hs_r;
      vs_p        <= vs_r;
      rgb_r       <= rgb;
      div         <= h_lead ? DW'(1 % CLK_DIV) : div == DW'(CLK_DIV - 1) ? '0 : div + DW'(1);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      mon_valid   <= vis;
      mon_rgb     <= vis ? rgb_r : '0;
      frame_start <= tick && h_nxt == '0 && v_nxt == '0;
      h_err       <= h_fail || (h_err && !clr_err);
      v_err       <= v_fail || (v_err && !clr_err);
      lit         <= v_lead ? '0 : lit + 19'(vis && rgb_r != '0);
      lit_count   <= v_lead ? lit : lit_count;
      frame_cnt   <= frame_cnt + 16'(v_lead && !search);
    end
  end
  always_comb begin
    state_nxt = search ? (v_lead ? ACQUIRE : SEARCH) :
                (h_fail || v_fail) ? ACQUIRE : v_lead ? LOCKED : state;
  end
  always_comb begin
    locked = state == LOCKED;
  end
endmodule
